// File: rtl/plab5_mcore_mem_req_net_adapter.sv
// Memory-request to network adapter: buffers requests, stamps dest/src/sequence, limits in-flight count.
// Optional macro PLAB5_MCORE_MEM_NET_DOMAIN_TAG_EN prepends a latched domain bit to the control payload.
module plab5_mcore_mem_req_net_adapter #(
  parameter int p_net_src           = 0,
  parameter int p_num_banks         = 4,
  parameter int p_mem_opaque_nbits  = 8,
  parameter int p_mem_addr_nbits    = 32,
  parameter int p_mem_data_nbits    = 32,
  parameter int p_net_opaque_nbits  = 4,
  parameter int p_net_srcdest_nbits = 3,
  parameter int p_cacheline_nwords  = 4,
  parameter int p_queue_depth       = 2,
  parameter int p_max_outstanding   = 4,
`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_TAG_EN
  localparam int c_tag_nbits = 1,
`else
  localparam int c_tag_nbits = 0,
`endif
  localparam int c_len_nbits  = $clog2(p_mem_data_nbits / 8),
  localparam int c_ctrl_nbits = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + c_len_nbits,
  localparam int c_pay_nbits  = c_ctrl_nbits + c_tag_nbits,
  localparam int c_net_nbits  = c_pay_nbits + p_net_opaque_nbits + 2 * p_net_srcdest_nbits,
  localparam int c_msg_nbits  = c_ctrl_nbits + p_mem_data_nbits
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        domain,
  input  logic [c_msg_nbits-1:0]      mem_req_msg,
  input  logic                        mem_req_val,
  output logic                        mem_req_rdy,
  output logic [c_net_nbits-1:0]      net_msg_control,
  output logic [p_mem_data_nbits-1:0] net_msg_data,
  output logic                        net_val,
  input  logic                        net_rdy,
  input  logic                        resp_done,
  output logic [3:0]                  outstanding
);

  localparam int c_bank_nbits = (p_num_banks > 1) ? $clog2(p_num_banks) : 1;
  localparam int c_lsb        = 2 + $clog2(p_cacheline_nwords);
  localparam int c_ptr_nbits  = $clog2(p_queue_depth);
  localparam int c_cnt_nbits  = $clog2(p_queue_depth + 1);
  localparam int c_mo         = p_mem_opaque_nbits;
  localparam int c_ns         = p_net_srcdest_nbits;
  localparam int c_md         = p_mem_data_nbits;
  localparam int c_ma         = p_mem_addr_nbits;
  localparam logic [c_ns-1:0] c_src = c_ns'(p_net_src);

  typedef enum logic [1:0] {IDLE, SEND, STALL} state_t;

  logic [c_md-1:0]              w_data;
  logic [c_len_nbits-1:0]       w_len;
  logic [c_ma-1:0]              w_addr;
  logic [c_mo-1:0]              w_opq;
  logic [2:0]                   w_type;
  logic [c_ns-1:0]              w_dest;
  logic [c_mo-1:0]              w_new_opq;
  logic [c_net_nbits-1:0]       w_entry;
  logic                         w_enq;
  logic                         w_deq;
  logic [c_cnt_nbits-1:0]       w_count_next;
  logic [3:0]                   w_outs_next;
  state_t                       w_state_next;

  logic [c_net_nbits-1:0]       r_ctrl [p_queue_depth];
  logic [c_md-1:0]              r_data [p_queue_depth];
  logic [c_ptr_nbits-1:0]       r_head;
  logic [c_ptr_nbits-1:0]       r_tail;
  logic [c_cnt_nbits-1:0]       r_count;
  logic [p_net_opaque_nbits-1:0] r_seq;
  logic [3:0]                   r_outs;
  state_t                       r_state;

  function automatic logic [c_ptr_nbits-1:0] f_ptr_inc(input logic [c_ptr_nbits-1:0] p);
    return (p == c_ptr_nbits'(p_queue_depth - 1)) ? '0 : p + c_ptr_nbits'(1);
  endfunction

  assign w_data = mem_req_msg[c_md-1:0];
  assign w_len  = mem_req_msg[c_md +: c_len_nbits];
  assign w_addr = mem_req_msg[c_md + c_len_nbits +: c_ma];
  assign w_opq  = mem_req_msg[c_md + c_len_nbits + c_ma +: c_mo];
  assign w_type = mem_req_msg[c_md + c_len_nbits + c_ma + c_mo +: 3];

  // Requester id replaces the top opaque bits so responses can be routed back here.
  assign w_new_opq = {c_src, w_opq[c_mo-c_ns-1:0]};

  generate
    if (p_num_banks == 1) begin : g_one_bank
      assign w_dest = '0;
    end else begin : g_banks
      assign w_dest = c_ns'(w_addr[c_lsb +: c_bank_nbits]);
    end
  endgenerate

`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_TAG_EN
  assign w_entry = {w_dest, c_src, r_seq, domain, w_type, w_new_opq, w_addr, w_len};
  logic w_unused;
  assign w_unused = &{1'b0, w_opq[c_mo-1 -: c_ns]};
`else
  assign w_entry = {w_dest, c_src, r_seq, w_type, w_new_opq, w_addr, w_len};
  logic w_unused;
  assign w_unused = &{1'b0, domain, w_opq[c_mo-1 -: c_ns]};
`endif

  assign mem_req_rdy     = !reset && (r_count != c_cnt_nbits'(p_queue_depth));
  assign net_val         = (r_state == SEND);
  assign net_msg_control = r_ctrl[r_head];
  assign net_msg_data    = r_data[r_head];
  assign outstanding     = r_outs;
  assign w_enq           = mem_req_val && mem_req_rdy;
  assign w_deq           = net_val && net_rdy;

  // State mirrors next-cycle occupancy and credit so net_val is a clean register decode.
  always_comb begin
    w_count_next = r_count;
    w_outs_next  = r_outs;
    w_state_next = IDLE;
    if (w_enq && !w_deq)
      w_count_next = r_count + c_cnt_nbits'(1);
    else if (w_deq && !w_enq)
      w_count_next = r_count - c_cnt_nbits'(1);
    if (w_deq && !resp_done)
      w_outs_next = r_outs + 4'd1;
    else if (!w_deq && resp_done && (r_outs != 4'd0))
      w_outs_next = r_outs - 4'd1;
    if (w_count_next != '0)
      w_state_next = (w_outs_next < 4'(p_max_outstanding)) ? SEND : STALL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_seq   <= '0;
      r_outs  <= '0;
      r_state <= IDLE;
    end else begin
      if (w_enq) begin
        r_tail <= f_ptr_inc(r_tail);
        r_seq  <= r_seq + p_net_opaque_nbits'(1);
      end
      if (w_deq)
        r_head <= f_ptr_inc(r_head);
      r_count <= w_count_next;
      r_outs  <= w_outs_next;
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_ctrl[r_tail] <= w_entry;
      r_data[r_tail] <= w_data;
    end
  end

endmodule

// File: tb/tb_plab5_mcore_mem_req_net_adapter.sv
// Randomized, model-checked bench for plab5_mcore_mem_req_net_adapter (depth 2, max outstanding 2, src 2).
module tb_plab5_mcore_mem_req_net_adapter;

  localparam int MO = 8, MA = 32, MD = 32, NO = 4, NS = 3, LENB = 2;
`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_TAG_EN
  localparam int TAGB = 1;
`else
  localparam int TAGB = 0;
`endif
  localparam int PC = 3 + MO + MA + LENB;
  localparam int P = PC + TAGB;
  localparam int NETW = P + NO + 2 * NS;
  localparam int MSGW = PC + MD;
  localparam int DEPTH = 2, MAXO = 2, SRC = 2;
  localparam int OPQ_LSB = LENB + MA;
  localparam int SEQ_LSB = P;
  localparam int SRC_LSB = P + NO;
  localparam int DEST_LSB = P + NO + NS;

  logic clk = 1'b0;
  logic reset, domain, mem_req_val, net_rdy, resp_done;
  logic [MSGW-1:0] mem_req_msg;
  logic mem_req_rdy, net_val;
  logic [NETW-1:0] net_msg_control;
  logic [MD-1:0] net_msg_data;
  logic [3:0] outstanding;

  plab5_mcore_mem_req_net_adapter #(
    .p_net_src(SRC), .p_num_banks(4), .p_mem_opaque_nbits(MO), .p_mem_addr_nbits(MA),
    .p_mem_data_nbits(MD), .p_net_opaque_nbits(NO), .p_net_srcdest_nbits(NS),
    .p_cacheline_nwords(4), .p_queue_depth(DEPTH), .p_max_outstanding(MAXO)
  ) dut (
    .clk(clk), .reset(reset), .domain(domain), .mem_req_msg(mem_req_msg),
    .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .net_msg_control(net_msg_control),
    .net_msg_data(net_msg_data), .net_val(net_val), .net_rdy(net_rdy),
    .resp_done(resp_done), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NETW-1:0] ctrl;
    logic [MD-1:0]   data;
  } exp_t;

  exp_t exp_q[$];
  int m_seq, m_outs;
  int n_checks, n_fail;

  logic [2:0]  s_type;
  logic [7:0]  s_opq;
  logic [31:0] s_addr;
  logic [1:0]  s_len;
  logic [31:0] s_data;

  // Expected network header+payload for the current stimulus fields, from the adapter's rules.
  function automatic logic [NETW-1:0] exp_ctrl(input int seq);
    logic [2:0] d3;
    logic [2:0] src3;
    logic [3:0] q4;
    logic [7:0] nopq;
    d3   = 3'((s_addr / 16) % 4);
    src3 = 3'(SRC);
    q4   = 4'(seq % 16);
    nopq = 8'(64 + (s_opq % 32));
`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_TAG_EN
    return {d3, src3, q4, domain, s_type, nopq, s_addr, s_len};
`else
    return {d3, src3, q4, s_type, nopq, s_addr, s_len};
`endif
  endfunction

  task automatic set_req(input logic [31:0] a, input logic [7:0] o);
    s_addr = a;
    s_opq  = o;
    s_type = 3'($urandom_range(0, 7));
    s_len  = 2'($urandom_range(0, 3));
    s_data = $urandom;
  endtask

  task automatic drive(input logic v, input logic nr, input logic rd);
    @(negedge clk);
    mem_req_val = v;
    mem_req_msg = {s_type, s_opq, s_addr, s_len, s_data};
    net_rdy     = nr;
    resp_done   = rd;
    #1;
  endtask

  // Advances the reference model by one clock using the currently driven inputs.
  task automatic tick();
    logic acc, snd;
    if (reset) begin
      exp_q.delete();
      m_seq  = 0;
      m_outs = 0;
    end else begin
      acc = mem_req_val && (exp_q.size() < DEPTH);
      snd = (exp_q.size() > 0) && (m_outs < MAXO) && net_rdy;
      if (snd) void'(exp_q.pop_front());
      if (snd && !resp_done) m_outs++;
      else if (!snd && resp_done && m_outs > 0) m_outs--;
      if (acc) begin
        exp_q.push_back('{exp_ctrl(m_seq), s_data});
        m_seq = (m_seq + 1) % 16;
      end
    end
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (exp_q.size() > 0 || m_outs > 0); i++) begin
      drive(1'b0, 1'b1, m_outs > 0);
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (mem_req_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rdy: got %b expected 0", mem_req_rdy); end
    n_checks++; if (net_val !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_net_val: got %b expected 0", net_val); end
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("[TB] FAIL reset_outstanding: got %0d expected 0", outstanding); end
    tick();
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (mem_req_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL post_reset_rdy: got %b expected 1", mem_req_rdy); end
    n_checks++; if (net_val !== 1'b0) begin n_fail++; $display("[TB] FAIL post_reset_net_val: got %b expected 0", net_val); end
    tick();
  endtask

  task automatic test_dest();
    set_req(32'h0000_0030, 8'h01);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    set_req(32'h0000_0040, 8'h02);
    drive(1'b1, 1'b1, 1'b0);
    n_checks++; if (net_val !== 1'b1) begin n_fail++; $display("[TB] FAIL dest_a_val: got %b expected 1", net_val); end
    n_checks++; if (net_msg_control[DEST_LSB +: 3] !== 3'd3) begin n_fail++; $display("[TB] FAIL dest_a: got %0d expected 3", net_msg_control[DEST_LSB +: 3]); end
    n_checks++; if (net_msg_data !== exp_q[0].data) begin n_fail++; $display("[TB] FAIL dest_a_data: got %h expected %h", net_msg_data, exp_q[0].data); end
    tick();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++; if (net_val !== 1'b1) begin n_fail++; $display("[TB] FAIL dest_b_val: got %b expected 1", net_val); end
    n_checks++; if (net_msg_control[DEST_LSB +: 3] !== 3'd0) begin n_fail++; $display("[TB] FAIL dest_b: got %0d expected 0", net_msg_control[DEST_LSB +: 3]); end
    n_checks++; if (net_msg_control !== exp_q[0].ctrl) begin n_fail++; $display("[TB] FAIL dest_b_ctrl: got %h expected %h", net_msg_control, exp_q[0].ctrl); end
    tick();
    drain();
  endtask

  task automatic test_opaque();
    set_req(32'h0000_1234, 8'hFF);
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++; if (net_val !== 1'b1) begin n_fail++; $display("[TB] FAIL opq_val: got %b expected 1", net_val); end
    n_checks++; if (net_msg_control[OPQ_LSB +: 8] !== 8'h5F) begin n_fail++; $display("[TB] FAIL opq_rewrite: got %h expected 5f", net_msg_control[OPQ_LSB +: 8]); end
    n_checks++; if (net_msg_control[SRC_LSB +: 3] !== 3'd2) begin n_fail++; $display("[TB] FAIL src_field: got %0d expected 2", net_msg_control[SRC_LSB +: 3]); end
    n_checks++; if (net_msg_control !== exp_q[0].ctrl) begin n_fail++; $display("[TB] FAIL opq_ctrl: got %h expected %h", net_msg_control, exp_q[0].ctrl); end
    tick();
    drain();
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 3; i++) begin
      set_req($urandom, 8'($urandom));
      drive(1'b1, 1'b0, 1'b0);
      n_checks++; if (mem_req_rdy !== (i < 2)) begin n_fail++; $display("[TB] FAIL bp_rdy_%0d: got %b expected %b", i, mem_req_rdy, i < 2); end
      tick();
    end
    drive(1'b1, 1'b0, 1'b0);
    n_checks++; if (mem_req_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_hold_rdy: got %b expected 0", mem_req_rdy); end
    n_checks++; if (net_val !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_hold_val: got %b expected 1", net_val); end
    tick();
    drive(1'b1, 1'b1, 1'b0);
    n_checks++; if (mem_req_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_full_deq_rdy: got %b expected 0", mem_req_rdy); end
    n_checks++; if (net_msg_control !== exp_q[0].ctrl) begin n_fail++; $display("[TB] FAIL bp_head: got %h expected %h", net_msg_control, exp_q[0].ctrl); end
    tick();
    drive(1'b1, 1'b0, 1'b0);
    n_checks++; if (mem_req_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_reopen_rdy: got %b expected 1", mem_req_rdy); end
    tick();
    drain();
  endtask

  task automatic test_outstanding();
    set_req($urandom, 8'($urandom));
    drive(1'b1, 1'b1, 1'b0);
    tick();
    set_req($urandom, 8'($urandom));
    drive(1'b1, 1'b1, 1'b0);
    tick();
    set_req($urandom, 8'($urandom));
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++; if (net_val !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_val: got %b expected 0", net_val); end
    n_checks++; if (outstanding !== 4'd2) begin n_fail++; $display("[TB] FAIL stall_outs: got %0d expected 2", outstanding); end
    tick();
    drive(1'b0, 1'b1, 1'b1);
    n_checks++; if (net_val !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_done_val: got %b expected 0", net_val); end
    tick();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++; if (net_val !== 1'b1) begin n_fail++; $display("[TB] FAIL resume_val: got %b expected 1", net_val); end
    n_checks++; if (net_msg_control !== exp_q[0].ctrl) begin n_fail++; $display("[TB] FAIL resume_ctrl: got %h expected %h", net_msg_control, exp_q[0].ctrl); end
    tick();
    drive(1'b0, 1'b1, 1'b0);
    n_checks++; if (outstanding !== 4'd2) begin n_fail++; $display("[TB] FAIL resume_outs: got %0d expected 2", outstanding); end
    n_checks++; if (net_val !== 1'b0) begin n_fail++; $display("[TB] FAIL resume_empty_val: got %b expected 0", net_val); end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, 1'b1, 1'b0);
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("[TB] FAIL underflow: got %0d expected 0", outstanding); end
    tick();
  endtask

  task automatic test_sequence();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_req($urandom, 8'($urandom));
      drive(1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0);
      n_checks++; if (net_val !== 1'b1 || net_msg_control[SEQ_LSB +: 4] !== 4'(i % 16)) begin
        n_fail++; $display("[TB] FAIL seq_%0d: got val=%b seq=%0d expected val=1 seq=%0d", i, net_val, net_msg_control[SEQ_LSB +: 4], i % 16);
      end
      tick();
      drive(1'b0, 1'b0, 1'b1);
      tick();
    end
  endtask

  task automatic test_random();
    logic e_rdy, e_val;
    for (int c = 0; c < 400; c++) begin
      domain = 1'($urandom_range(0, 1));
      set_req($urandom, 8'($urandom));
      drive(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      e_rdy = exp_q.size() < DEPTH;
      e_val = (exp_q.size() > 0) && (m_outs < MAXO);
      n_checks++; if (mem_req_rdy !== e_rdy) begin n_fail++; $display("[TB] FAIL rnd_rdy c%0d: got %b expected %b", c, mem_req_rdy, e_rdy); end
      n_checks++; if (net_val !== e_val) begin n_fail++; $display("[TB] FAIL rnd_val c%0d: got %b expected %b", c, net_val, e_val); end
      n_checks++; if (outstanding !== 4'(m_outs)) begin n_fail++; $display("[TB] FAIL rnd_outs c%0d: got %0d expected %0d", c, outstanding, m_outs); end
      if (exp_q.size() > 0) begin
        n_checks++; if (net_msg_control !== exp_q[0].ctrl || net_msg_data !== exp_q[0].data) begin
          n_fail++; $display("[TB] FAIL rnd_msg c%0d: got %h/%h expected %h/%h", c, net_msg_control, net_msg_data, exp_q[0].ctrl, exp_q[0].data);
        end
      end
      tick();
    end
    domain = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    set_req($urandom, 8'($urandom));
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    domain = 1'b1;
    for (int i = 0; i < 2; i++) begin
      set_req($urandom, 8'($urandom));
      drive(1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (net_val !== 1'b1 || net_msg_control !== exp_q[0].ctrl) begin
      n_fail++; $display("[TB] FAIL mid_head: got val=%b %h expected val=1 %h", net_val, net_msg_control, exp_q[0].ctrl);
    end
`ifdef PLAB5_MCORE_MEM_NET_DOMAIN_TAG_EN
    n_checks++; if (net_msg_control[P-1] !== 1'b1) begin n_fail++; $display("[TB] FAIL domain_tag: got %b expected 1", net_msg_control[P-1]); end
`endif
    tick();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    n_checks++; if (net_val !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_val: got %b expected 0", net_val); end
    n_checks++; if (outstanding !== 4'd0) begin n_fail++; $display("[TB] FAIL mid_reset_outs: got %0d expected 0", outstanding); end
    n_checks++; if (mem_req_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_reset_rdy: got %b expected 0", mem_req_rdy); end
    tick();
    reset = 1'b0;
    domain = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      n_checks++; if (mem_req_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL after_reset_rdy_%0d: got %b expected 1", i, mem_req_rdy); end
      n_checks++; if (net_val !== 1'b0) begin n_fail++; $display("[TB] FAIL after_reset_val_%0d: got %b expected 0", i, net_val); end
      tick();
    end
  endtask

  initial begin
    reset       = 1'b1;
    domain      = 1'b0;
    mem_req_val = 1'b0;
    net_rdy     = 1'b0;
    resp_done   = 1'b0;
    mem_req_msg = '0;
    n_checks    = 0;
    n_fail      = 0;
    m_seq       = 0;
    m_outs      = 0;
    set_req(32'h0, 8'h0);
    $display("[TB] starting");
    test_reset();
    test_dest();
    test_opaque();
    test_backpressure();
    test_outstanding();
    test_sequence();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/plab5_mcore_mem_req_net_adapter.md
PLAB5_MCORE_MEM_REQ_NET_ADAPTER -- requirements
Module: plab5_mcore_mem_req_net_adapter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- p_net_src, 0: source port id.
- p_num_banks, 4: destination banks, power of 2, 1..8.
- p_mem_opaque_nbits, 8: mem opaque width (mo).
- p_mem_addr_nbits, 32: mem address width (ma).
- p_mem_data_nbits, 32: mem data width (md).
- p_net_opaque_nbits, 4: net opaque width (no).
- p_net_srcdest_nbits, 3: net src/dest width (ns); ns >= log2(p_num_banks), mo > ns.
- p_cacheline_nwords, 4: words per line; sets interleave LSB = 2+log2(p_cacheline_nwords).
- p_queue_depth, 2: buffer entries, 2..8.
- p_max_outstanding, 4: in-flight request limit, 1..15.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; reset is synchronous and active-high.
- reset, in, 1: synchronous active-high reset.
- domain, in, 1: security domain of the current request.
- mem_req_msg, in, VC_MEM_REQ_MSG_NBITS(mo,ma,md): memory request.
- mem_req_val / mem_req_rdy, in / out, 1 each: request handshake.
- net_msg_control, out, VC_NET_MSG_NBITS(P,no,ns), P = mem control-field width (+1 if tag enabled): header plus control payload.
- net_msg_data, out, md: data payload.
- net_val / net_rdy, out / in, 1 each: network handshake.
- resp_done, in, 1: one-cycle pulse per response returned to this port.
- outstanding, out, 4: current in-flight count.

Function
REQ-003 Transfer occurs on a channel only when val and rdy are both high on a rising edge of clk.
REQ-004 Accepted requests are enqueued into a FIFO of p_queue_depth entries.
- mem_req_rdy = !full, combinational, independent of mem_req_val.
- Latency enqueue-to-net_val = 1 cycle; no combinational bypass.
REQ-005 net_val = !empty && (outstanding < p_max_outstanding); net_msg_* driven from FIFO head, stable while net_val && !net_rdy.
REQ-006 Destination is computed at enqueue:
- p_num_banks == 1: dest = 0.
- otherwise: dest = addr[lsb +: log2(p_num_banks)], zero-extended to ns.
REQ-007 Mem opaque is rewritten at enqueue: upper ns bits = p_net_src[ns-1:0], lower mo-ns bits preserved.
- Type, addr, len: unchanged in net_msg_control payload.
- Data field goes to net_msg_data.
REQ-008 Net opaque = 'no'-bit sequence counter captured at enqueue.
- Reset value 0; +1 per enqueue.
- Wraps 2^no-1 -> 0.
REQ-009 net src field = p_net_src[ns-1:0].
REQ-010 outstanding counter:
- +1 on net transfer; -1 on resp_done.
- Both in the same cycle: unchanged.
- resp_done at 0: ignored, stays 0, no underflow.
REQ-011 FIFO full with simultaneous dequeue: mem_req_rdy remains low that cycle (no same-cycle pass-through).
- Empty: net_val = 0, net_msg_* undefined.
REQ-012 FIFO pointers wrap modulo p_queue_depth; non-power-of-2 depths supported.
REQ-013 Control-path state machine, states IDLE / SEND / STALL:
- IDLE: queue empty.
- SEND: head valid, credit available.
- STALL: head valid, outstanding == p_max_outstanding.
- STALL -> SEND on the first cycle a resp_done pulse is registered.

Reset
REQ-014 While reset is high:
- FIFO emptied; sequence counter = 0; outstanding = 0; state = IDLE.
- net_val = 0; mem_req_rdy = 0.
REQ-015 Reset mid-transfer discards all queued requests; no partial message is emitted after reset deasserts.
- mem_req_rdy = 1 on the first cycle after reset.

Configuration
REQ-016 Macro PLAB5_MCORE_MEM_NET_DOMAIN_TAG_EN.
- Defined: domain is latched per entry at enqueue and prepended as the MSB of the control payload (payload width +1).
- Undefined: no tag bit; domain input is unused; payload width = control-field width.

Verification
REQ-017 Bench scenarios:
- p_num_banks=4, lines of 4 words, addr 0x0000_0030 -> dest 3; addr 0x0000_0040 -> dest 0.
- p_net_src=2, ns=3, mo=8, opaque 0xFF -> net payload opaque 0x5F; net src field = 2.
- depth 2, net_rdy=0, send 3 requests -> first two accepted, mem_req_rdy low on the third until one net transfer.
- p_max_outstanding=2, net_rdy=1, 3 requests -> two sent, state STALL, net_val=0; one resp_done -> third sent next cycle, outstanding=2.
- no=4, 17 requests -> net opaque sequence 0..15 then 0.
- Reset asserted with 2 entries queued -> next cycle net_val=0, outstanding=0; with DOMAIN_TAG_EN and domain=1, payload MSB = 1.
